// File: rtl/mem_ctrl_if.sv
// Request/response bus between the cache controller (master) and the memory
// controller (slave).
interface mem_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              mem_cs;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              mem_busy;
    logic              mem_err;

    modport master (
        output mem_cs, mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready, mem_busy, mem_err
    );

    modport slave (
        input  mem_cs, mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_ready, mem_busy, mem_err
    );
endinterface

// File: rtl/mem_ctrl.sv
// Main-memory model: fixed-latency word array access with abort-on-withdrawal
// and a one-cycle registered completion pulse.
module mem_ctrl #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int LATENCY = 3
) (
    input  logic          clk,
    input  logic          reset,
    mem_ctrl_if.slave     bus
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept_s;
    logic              complete_s;
    logic              mem_we_s;

    assign accept_s   = (state_q == ST_IDLE) && bus.mem_cs && (bus.mem_rd ^ bus.mem_wr);
    // Withdrawal of mem_cs wins over completion on the same edge.
    assign complete_s = (state_q == ST_BUSY) && bus.mem_cs && (cnt_q == 4'd0);

    // State register, request latches, registered outputs and the word array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            if (mem_we_s) begin
                mem_q[addr_q] <= wdata_q;
            end
        end
    end

    // Next-state logic: acceptance, latency countdown, abort and return to idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_LOAD;
                    op_wr_d = bus.mem_wr;
                    addr_d  = bus.mem_addr;
                    wdata_d = bus.mem_wdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!bus.mem_cs) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output logic: next values of the registered handshake and read data.
    always_comb begin
        ready_d  = complete_s;
        busy_d   = (state_d != ST_IDLE);
        err_d    = (state_q == ST_IDLE) && bus.mem_cs && bus.mem_rd && bus.mem_wr;
        mem_we_s = complete_s && op_wr_q;
        if (complete_s && !op_wr_q) begin
            rdata_d = mem_q[addr_q];
        end else begin
            rdata_d = rdata_q;
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_ready = ready_q;
    assign bus.mem_busy  = busy_q;
    assign bus.mem_err   = err_q;
endmodule
